// File: rtl/pwm_duty_ramp_if.sv
// CPU output-port bus and PWM-facing duty outputs of the duty ramp block.
// The CPU side drives the port write; the ramp block drives DUTY/BUSY/DONE.
interface pwm_duty_ramp_if;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic [7:0] DUTY;
  logic       BUSY;
  logic       DONE;

  modport master (
    output PORT_ID, OUT_PORT, IO_STRB,
    input  DUTY, BUSY, DONE
  );

  modport slave (
    input  PORT_ID, OUT_PORT, IO_STRB,
    output DUTY, BUSY, DONE
  );
endinterface

// File: rtl/pwm_duty_ramp.sv
// Duty-cycle source for the 8-bit PWM. CPU port writes set a target and a
// config byte; DUTY slews toward the target one step per prescaler tick,
// or jumps straight to it when IMMEDIATE is set.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | DUTY equals TARGET, or immediate mode active
// UP    | ramping DUTY upward toward TARGET
// DOWN  | ramping DUTY downward toward TARGET
module pwm_duty_ramp #(
  parameter logic [7:0] TARGET_ADDR = 8'h42,
  parameter logic [7:0] CFG_ADDR    = 8'h43,
  parameter int         PRESCALE    = 256
) (
  input  logic             CLK,
  input  logic             RST,
  pwm_duty_ramp_if.slave   bus
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] UP   = 2'b01;
  localparam logic [1:0] DOWN = 2'b10;

  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

  logic [15:0] presc;
  logic        tick;

  logic [7:0]  target;
  logic        cfg_imm;
  logic [2:0]  cfg_rsvd_unused;
  logic [3:0]  cfg_step;

  logic [1:0]  state, state_nxt;
  logic [7:0]  duty, duty_nxt;
  logic        done_q, done_nxt;

  logic [7:0]  step;
  logic [8:0]  up_diff, dn_diff;

  assign tick = (presc == PRESC_LAST);

  // Free-running prescaler; tick marks the last count of each period.
  always_ff @(posedge CLK) begin
    if (RST)       presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 16'd1;
  end

  // CPU port write decode into the target and config registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      target          <= 8'h00;
      cfg_imm         <= 1'b0;
      cfg_rsvd_unused <= 3'b000;
      cfg_step        <= 4'h1;
    end else if (bus.IO_STRB) begin
      if (bus.PORT_ID == TARGET_ADDR) target <= bus.OUT_PORT;
      if (bus.PORT_ID == CFG_ADDR) begin
        cfg_imm         <= bus.OUT_PORT[7];
        cfg_rsvd_unused <= bus.OUT_PORT[6:4];
        cfg_step        <= bus.OUT_PORT[3:0];
      end
    end
  end

  // A zero step would stall the ramp forever, so it is promoted to 1.
  assign step    = {4'd0, (cfg_step == 4'd0) ? 4'd1 : cfg_step};
  assign up_diff = {1'b0, target} - {1'b0, duty};
  assign dn_diff = {1'b0, duty} - {1'b0, target};

  // Next-state and next-duty: saturate at TARGET, reverse on a target rewrite.
  always_comb begin
    state_nxt = state;
    duty_nxt  = duty;
    done_nxt  = 1'b0;
    if (cfg_imm) begin
      state_nxt = IDLE;
      duty_nxt  = target;
    end else begin
      case (state)
        IDLE: begin
          if (target > duty)      state_nxt = UP;
          else if (target < duty) state_nxt = DOWN;
        end
        UP: begin
          if (target == duty)     state_nxt = IDLE;
          else if (target < duty) state_nxt = DOWN;
          else if (tick) begin
            if (up_diff <= {1'b0, step}) begin
              duty_nxt  = target;
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end else begin
              duty_nxt = duty + step;
            end
          end
        end
        DOWN: begin
          if (target == duty)     state_nxt = IDLE;
          else if (target > duty) state_nxt = UP;
          else if (tick) begin
            if (dn_diff <= {1'b0, step}) begin
              duty_nxt  = target;
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end else begin
              duty_nxt = duty - step;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Ramp state, duty and done pulse registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      duty   <= 8'h00;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      duty   <= duty_nxt;
      done_q <= done_nxt;
    end
  end

  assign bus.DUTY = duty;
  assign bus.BUSY = (state != IDLE);
  assign bus.DONE = done_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp with a queue-based scoreboard: stimulus
// pushes expected DUTY steps and DONE values, a monitor pops them whenever
// DUTY changes or DONE pulses.
module tb_pwm_duty_ramp;

  localparam logic [7:0] TADDR = 8'h42;
  localparam logic [7:0] CADDR = 8'h43;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  pwm_duty_ramp_if bus();

  pwm_duty_ramp #(.TARGET_ADDR(TADDR), .CFG_ADDR(CADDR), .PRESCALE(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] duty;
    int         gap;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] done_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic pexp(input logic [7:0] d, input int gap);
    exp_t e;
    e.duty = d;
    e.gap  = gap;
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    bus.PORT_ID  = addr;
    bus.OUT_PORT = data;
    bus.IO_STRB  = 1'b1;
    @(posedge CLK);
    #1;
    bus.IO_STRB  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < 200) begin
      @(negedge CLK);
      #1;
      n++;
    end
    vectors++;
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: timed out with %0d duty steps and %0d done pulses still expected",
               name, exp_q.size(), done_q.size());
      exp_q.delete();
      done_q.delete();
    end
  endtask

  // Monitor: every DUTY change and DONE pulse must match the scoreboard.
  initial begin
    logic [7:0] prev;
    logic [7:0] d;
    exp_t       e;
    int         cyc;
    int         last_chg;
    prev = 8'h00;
    cyc = 0;
    last_chg = 0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (RST) begin
        prev = bus.DUTY;
      end else begin
        if (bus.DUTY !== prev) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_duty_change: got %0h, required %0h (t=%0t)", bus.DUTY, prev, $time);
          end else begin
            e = exp_q.pop_front();
            check("duty_step", bus.DUTY, e.duty);
            if (e.gap != 0) begin
              vectors++;
              if (cyc - last_chg != e.gap) begin
                miscompares++;
                $display("FAIL step_interval: got %0d clocks, required %0d (t=%0t)", cyc - last_chg, e.gap, $time);
              end
            end
          end
          last_chg = cyc;
          prev = bus.DUTY;
        end
        if (bus.DONE === 1'b1) begin
          if (done_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_done: got 1, required 0 (duty %0h, t=%0t)", bus.DUTY, $time);
          end else begin
            d = done_q.pop_front();
            check("done_duty", bus.DUTY, d);
            check("busy_at_done", {7'd0, bus.BUSY}, 8'h00);
            vectors++;
            if (last_chg != cyc) begin
              miscompares++;
              $display("FAIL done_timing: got done %0d clocks after reach, required 0", cyc - last_chg);
            end
          end
        end
      end
    end
  end

  initial begin
    bus.PORT_ID  = 8'h00;
    bus.OUT_PORT = 8'h00;
    bus.IO_STRB  = 1'b0;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    // Reset idle, no writes.
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      check("reset_duty", bus.DUTY, 8'h00);
      check("reset_busy", {7'd0, bus.BUSY}, 8'h00);
      check("reset_done", {7'd0, bus.DONE}, 8'h00);
    end

    // Ramp up 0 -> 10, step 4.
    wr(CADDR, 8'h04);
    pexp(8'd4, 0); pexp(8'd8, 4); pexp(8'd10, 4);
    done_q.push_back(8'd10);
    wr(TADDR, 8'd10);
    @(negedge CLK);
    check("busy_before_entry", {7'd0, bus.BUSY}, 8'h00);
    @(negedge CLK);
    check("busy_after_entry", {7'd0, bus.BUSY}, 8'h01);
    drain("ramp_up");

    // Ramp down 10 -> 0, step 3, no underflow.
    wr(CADDR, 8'h03);
    pexp(8'd7, 0); pexp(8'd4, 4); pexp(8'd1, 4); pexp(8'd0, 4);
    done_q.push_back(8'd0);
    wr(TADDR, 8'd0);
    drain("ramp_down");

    // Immediate mode.
    wr(CADDR, 8'h80);
    pexp(8'h77, 0);
    wr(TADDR, 8'h77);
    check("imm_duty_at_write", bus.DUTY, 8'h00);
    @(posedge CLK);
    #1;
    check("imm_duty_next_edge", bus.DUTY, 8'h77);
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check("imm_busy", {7'd0, bus.BUSY}, 8'h00);
      check("imm_done", {7'd0, bus.DONE}, 8'h00);
    end
    drain("imm_77");
    pexp(8'hF8, 0);
    wr(TADDR, 8'hF8);
    drain("imm_f8");

    // Saturation at 255 with step 15.
    wr(CADDR, 8'h0F);
    pexp(8'hFF, 0);
    done_q.push_back(8'hFF);
    wr(TADDR, 8'hFF);
    drain("sat_ff");

    // STEP=0 behaves as 1.
    wr(CADDR, 8'h00);
    pexp(8'hFE, 0); pexp(8'hFD, 4); pexp(8'hFC, 4);
    done_q.push_back(8'hFC);
    wr(TADDR, 8'hFC);
    drain("step_zero");

    // Reversal: ramp toward 200, rewrite to 20 at DUTY=50.
    wr(CADDR, 8'h80);
    pexp(8'd40, 0);
    wr(TADDR, 8'd40);
    drain("rev_setup");
    wr(CADDR, 8'h05);
    pexp(8'd45, 0); pexp(8'd50, 4);
    wr(TADDR, 8'd200);
    drain("rev_up");
    pexp(8'd45, 4); pexp(8'd40, 4); pexp(8'd35, 4);
    pexp(8'd30, 4); pexp(8'd25, 4); pexp(8'd20, 4);
    done_q.push_back(8'd20);
    wr(TADDR, 8'd20);
    @(negedge CLK);
    check("rev_busy", {7'd0, bus.BUSY}, 8'h01);
    check("rev_hold", bus.DUTY, 8'd50);
    drain("rev_down");

    // Reset mid-ramp with a simultaneous write that must be dropped.
    pexp(8'd25, 0);
    wr(TADDR, 8'd100);
    drain("rst_setup");
    pexp(8'd0, 0);
    bus.PORT_ID  = TADDR;
    bus.OUT_PORT = 8'h33;
    bus.IO_STRB  = 1'b1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    bus.IO_STRB = 1'b0;
    check("rst_duty", bus.DUTY, 8'h00);
    check("rst_busy", {7'd0, bus.BUSY}, 8'h00);
    check("rst_done", {7'd0, bus.DONE}, 8'h00);
    drain("rst_duty_change");
    repeat (20) @(negedge CLK);
    check("rst_write_dropped", bus.DUTY, 8'h00);
    pexp(8'd1, 0); pexp(8'd2, 4); pexp(8'd3, 4);
    done_q.push_back(8'd3);
    wr(TADDR, 8'd3);
    drain("rst_cfg_default");

    // Write to an unmapped address changes nothing.
    wr(8'h44, 8'h55);
    repeat (30) @(negedge CLK);
    check("unmapped_duty", bus.DUTY, 8'd3);
    pexp(8'd4, 0); pexp(8'd5, 4); pexp(8'd6, 4);
    pexp(8'd7, 4); pexp(8'd8, 4); pexp(8'd9, 4);
    done_q.push_back(8'd9);
    wr(TADDR, 8'd9);
    drain("unmapped_cfg_intact");

    repeat (10) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
